// File: rtl/async_fifo_param.sv
// async_fifo_param: dual-clock FIFO with Gray-coded pointer crossing, per-side
// occupancy counts, almost-full/almost-empty thresholds and sticky error flags.
module async_fifo_param #(
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 4,
  parameter int SYNC_STAGES = 2,
  parameter int AF_LEVEL    = 2**ADDR_W - 2,
  parameter int AE_LEVEL    = 2
) (
  input  logic              wr_clk,
  input  logic              reset,
  input  logic              rd_clk,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] data_in,
  output logic              wr_full,
  output logic              wr_almost_full,
  output logic [ADDR_W:0]   wr_count,
  output logic              wr_overflow,
  input  logic              rd_en,
  output logic [DATA_W-1:0] data_out,
  output logic              rd_empty,
  output logic              rd_almost_empty,
  output logic [ADDR_W:0]   rd_count,
  output logic              rd_underflow
);
  localparam int DEPTH = 2**ADDR_W;
  localparam logic [ADDR_W:0] AF = (ADDR_W+1)'(AF_LEVEL);
  localparam logic [ADDR_W:0] AE = (ADDR_W+1)'(AE_LEVEL);

  function automatic logic [ADDR_W:0] g2b(input logic [ADDR_W:0] g);
    for (int i = 0; i <= ADDR_W; i++) g2b[i] = ^(g >> i);
  endfunction

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W:0] wbin, wgray, wbin_nx, wgray_nx;
  logic [ADDR_W:0] rbin, rgray, rbin_nx, rgray_nx;
  logic [SYNC_STAGES-1:0][ADDR_W:0] rq, wq;
  logic [SYNC_STAGES-1:0] rst_sync;
  logic rd_live, w_acc, r_acc;

  assign rd_live  = rst_sync[SYNC_STAGES-1];
  assign w_acc    = reset && wr_en && !wr_full;
  assign r_acc    = rd_live && rd_en && !rd_empty;
  assign wbin_nx  = wbin + (ADDR_W+1)'(w_acc);
  assign wgray_nx = (wbin_nx >> 1) ^ wbin_nx;
  assign rbin_nx  = rbin + (ADDR_W+1)'(r_acc);
  assign rgray_nx = (rbin_nx >> 1) ^ rbin_nx;
  assign wr_almost_full  = wr_count >= AF;
  assign rd_almost_empty = rd_count <= AE;

  always_ff @(posedge wr_clk)
    if (w_acc) mem[wbin[ADDR_W-1:0]] <= data_in;

  always_ff @(posedge wr_clk)
    if (!reset) begin
      wbin        <= '0;
      wgray       <= '0;
      wr_full     <= 1'b0;
      wr_count    <= '0;
      wr_overflow <= 1'b0;
      rq          <= '0;
    end else begin
      wbin        <= wbin_nx;
      wgray       <= wgray_nx;
      wr_full     <= wgray_nx == {~rq[SYNC_STAGES-1][ADDR_W -: 2], rq[SYNC_STAGES-1][ADDR_W-2:0]};
      wr_count    <= wbin_nx - g2b(rq[SYNC_STAGES-1]);
      wr_overflow <= wr_overflow | (wr_en & wr_full);
      rq          <= {rq[SYNC_STAGES-2:0], rgray};
    end

  // a single sampled low on reset is enough to pulse the read-side reset
  always_ff @(posedge rd_clk)
    rst_sync <= {rst_sync[SYNC_STAGES-2:0], reset};

  always_ff @(posedge rd_clk)
    if (!rd_live) begin
      rbin         <= '0;
      rgray        <= '0;
      rd_empty     <= 1'b1;
      rd_count     <= '0;
      rd_underflow <= 1'b0;
      data_out     <= '0;
      wq           <= '0;
    end else begin
      rbin         <= rbin_nx;
      rgray        <= rgray_nx;
      rd_empty     <= rgray_nx == wq[SYNC_STAGES-1];
      rd_count     <= g2b(wq[SYNC_STAGES-1]) - rbin_nx;
      rd_underflow <= rd_underflow | (rd_en & rd_empty);
      data_out     <= r_acc ? mem[rbin[ADDR_W-1:0]] : data_out;
      wq           <= {wq[SYNC_STAGES-2:0], wgray};
    end
endmodule

// File: tb/tb_async_fifo_param.sv
// tb_async_fifo_param: scenario tasks against a queue model of the FIFO contents.
module tb_async_fifo_param;
  timeunit 1us;
  timeprecision 1ns;

  localparam int S = 2;

  logic wr_clk = 0, rd_clk = 0, reset = 0, wr_en = 0, rd_en = 0;
  logic [7:0] data_in = 0;
  logic wr_full, wr_almost_full, wr_overflow, rd_empty, rd_almost_empty, rd_underflow;
  logic [4:0] wr_count, rd_count;
  logic [7:0] data_out;
  int n_cmp = 0, n_bad = 0;
  logic [7:0] model[$];

  async_fifo_param dut (
    .wr_clk(wr_clk), .reset(reset), .rd_clk(rd_clk),
    .wr_en(wr_en), .data_in(data_in), .wr_full(wr_full),
    .wr_almost_full(wr_almost_full), .wr_count(wr_count), .wr_overflow(wr_overflow),
    .rd_en(rd_en), .data_out(data_out), .rd_empty(rd_empty),
    .rd_almost_empty(rd_almost_empty), .rd_count(rd_count), .rd_underflow(rd_underflow)
  );

  always #2 wr_clk = ~wr_clk;
  always #5 rd_clk = ~rd_clk;

  task automatic write_word(input logic [7:0] d);
    int g = 0;
    @(negedge wr_clk);
    while (wr_full && g < 50) begin
      @(negedge wr_clk);
      g++;
    end
    if (wr_full) begin
      n_cmp++;
      n_bad++;
      $display("FAIL write_wait: wr_full stuck at 1, want 0");
    end
    wr_en = 1;
    data_in = d;
    @(negedge wr_clk);
    wr_en = 0;
  endtask

  task automatic read_word(output logic [7:0] d);
    int g = 0;
    @(negedge rd_clk);
    while (rd_empty && g < 50) begin
      @(negedge rd_clk);
      g++;
    end
    if (rd_empty) begin
      n_cmp++;
      n_bad++;
      $display("FAIL read_wait: rd_empty stuck at 1, want 0");
    end
    rd_en = 1;
    @(negedge rd_clk);
    rd_en = 0;
    d = data_out;
  endtask

  task automatic test_reset;
    logic [23:0] exp_v = {6'b000110, 5'd0, 5'd0, 8'h00};
    reset = 0;
    repeat (10) @(negedge wr_clk);
    n_cmp++;
    if ({wr_full, wr_almost_full, wr_overflow, rd_empty, rd_almost_empty, rd_underflow, wr_count, rd_count, data_out} !== exp_v) begin
      n_bad++;
      $display("FAIL reset_state: got %h want %h",
        {wr_full, wr_almost_full, wr_overflow, rd_empty, rd_almost_empty, rd_underflow, wr_count, rd_count, data_out}, exp_v);
    end
    reset = 1;
    repeat (4) @(negedge rd_clk);
    n_cmp++;
    if ({wr_full, wr_almost_full, wr_overflow, rd_empty, rd_almost_empty, rd_underflow, wr_count, rd_count, data_out} !== exp_v) begin
      n_bad++;
      $display("FAIL reset_idle: got %h want %h",
        {wr_full, wr_almost_full, wr_overflow, rd_empty, rd_almost_empty, rd_underflow, wr_count, rd_count, data_out}, exp_v);
    end
  endtask

  task automatic test_fill_drain;
    int k = 0;
    logic [7:0] d;
    @(negedge wr_clk);
    wr_en = 1;
    data_in = 8'h01;
    @(posedge wr_clk);
    fork begin @(negedge wr_clk); wr_en = 0; end join_none
    do begin @(posedge rd_clk); k++; #1; end while (rd_empty && k < S + 2);
    n_cmp++;
    if (rd_empty !== 1'b0) begin
      n_bad++;
      $display("FAIL wr_to_rd_latency: rd_empty=%b after %0d rd edges, want 0", rd_empty, k);
    end
    for (int i = 2; i <= 16; i++) write_word(i[7:0]);
    n_cmp++;
    if ({wr_full, wr_count} !== {1'b1, 5'd16}) begin
      n_bad++;
      $display("FAIL fill_full: wr_full=%b wr_count=%0d, want 1 and 16", wr_full, wr_count);
    end
    repeat (6) @(negedge rd_clk);
    n_cmp++;
    if (rd_count !== 5'd16) begin
      n_bad++;
      $display("FAIL fill_rd_count: got %0d want 16", rd_count);
    end
    @(negedge rd_clk);
    rd_en = 1;
    @(posedge rd_clk);
    k = 0;
    fork
      begin @(negedge rd_clk); rd_en = 0; d = data_out; end
      do begin @(posedge wr_clk); k++; #1; end while (wr_full && k < S + 2);
    join
    n_cmp++;
    if (wr_full !== 1'b0) begin
      n_bad++;
      $display("FAIL rd_to_wr_latency: wr_full=%b after %0d wr edges, want 0", wr_full, k);
    end
    n_cmp++;
    if (d !== 8'h01) begin
      n_bad++;
      $display("FAIL drain_data0: got %h want 01", d);
    end
    for (int i = 2; i <= 16; i++) begin
      read_word(d);
      n_cmp++;
      if (d !== i[7:0]) begin
        n_bad++;
        $display("FAIL drain_data: got %h want %h", d, i[7:0]);
      end
    end
    n_cmp++;
    if ({rd_empty, rd_count} !== {1'b1, 5'd0}) begin
      n_bad++;
      $display("FAIL drain_empty: rd_empty=%b rd_count=%0d, want 1 and 0", rd_empty, rd_count);
    end
  endtask

  task automatic test_overflow;
    logic [7:0] d;
    for (int i = 0; i < 16; i++) write_word(8'h20 + i[7:0]);
    @(negedge wr_clk);
    wr_en = 1;
    data_in = 8'hAA;
    @(negedge wr_clk);
    wr_en = 0;
    n_cmp++;
    if ({wr_overflow, wr_full, wr_count} !== {1'b1, 1'b1, 5'd16}) begin
      n_bad++;
      $display("FAIL overflow_flag: ovf=%b full=%b count=%0d, want 1 1 16", wr_overflow, wr_full, wr_count);
    end
    repeat (6) @(negedge rd_clk);
    for (int i = 0; i < 16; i++) begin
      read_word(d);
      n_cmp++;
      if (d !== 8'h20 + i[7:0]) begin
        n_bad++;
        $display("FAIL overflow_data: got %h want %h", d, 8'h20 + i[7:0]);
      end
    end
    repeat (6) @(negedge wr_clk);
    n_cmp++;
    if ({wr_overflow, rd_empty, wr_count} !== {1'b1, 1'b1, 5'd0}) begin
      n_bad++;
      $display("FAIL overflow_after: ovf=%b empty=%b wr_count=%0d, want 1 1 0", wr_overflow, rd_empty, wr_count);
    end
  endtask

  task automatic test_underflow;
    logic [7:0] d;
    @(negedge rd_clk);
    rd_en = 1;
    @(negedge rd_clk);
    rd_en = 0;
    n_cmp++;
    if ({rd_underflow, rd_empty, data_out} !== {1'b1, 1'b1, 8'h2F}) begin
      n_bad++;
      $display("FAIL underflow_flag: udf=%b empty=%b data_out=%h, want 1 1 2f", rd_underflow, rd_empty, data_out);
    end
    write_word(8'h77);
    read_word(d);
    n_cmp++;
    if ({d, rd_underflow} !== {8'h77, 1'b1}) begin
      n_bad++;
      $display("FAIL underflow_after: data=%h udf=%b, want 77 1", d, rd_underflow);
    end
  endtask

  task automatic test_stream;
    int wn = 0, rn = 0, wg = 0, rg = 0;
    logic pend = 0;
    logic [7:0] exp_d;
    model.delete();
    fork
      begin
        while (wn < 100 && wg < 4000) begin
          @(negedge wr_clk);
          wg++;
          n_cmp++;
          if (wr_almost_full !== (wr_count >= 5'd14)) begin
            n_bad++;
            $display("FAIL stream_af: wr_almost_full=%b wr_count=%0d", wr_almost_full, wr_count);
          end
          n_cmp++;
          if (wr_full !== (wr_count == 5'd16)) begin
            n_bad++;
            $display("FAIL stream_full: wr_full=%b wr_count=%0d", wr_full, wr_count);
          end
          if (!wr_full && $urandom_range(0, 3) != 0) begin
            wr_en = 1;
            data_in = wn[7:0];
            model.push_back(wn[7:0]);
            wn++;
          end else wr_en = 0;
        end
        @(negedge wr_clk);
        wr_en = 0;
      end
      while (rn < 100 && rg < 4000) begin
        @(negedge rd_clk);
        rg++;
        if (pend) begin
          n_cmp++;
          if (model.size() == 0) begin
            n_bad++;
            $display("FAIL stream_data: got %h, want no data (model empty)", data_out);
          end else begin
            exp_d = model.pop_front();
            if (data_out !== exp_d) begin
              n_bad++;
              $display("FAIL stream_data: got %h want %h", data_out, exp_d);
            end
          end
          rn++;
        end
        n_cmp++;
        if (rd_almost_empty !== (rd_count <= 5'd2)) begin
          n_bad++;
          $display("FAIL stream_ae: rd_almost_empty=%b rd_count=%0d", rd_almost_empty, rd_count);
        end
        n_cmp++;
        if (rd_empty !== (rd_count == 5'd0)) begin
          n_bad++;
          $display("FAIL stream_empty: rd_empty=%b rd_count=%0d", rd_empty, rd_count);
        end
        pend = rn < 100 && !rd_empty && $urandom_range(0, 3) != 0;
        rd_en = pend;
      end
    join
    rd_en = 0;
    n_cmp++;
    if (wn != 100 || rn != 100) begin
      n_bad++;
      $display("FAIL stream_timeout: wrote %0d read %0d, want 100 100", wn, rn);
    end
    repeat (8) @(negedge rd_clk);
    n_cmp++;
    if ({rd_empty, rd_count, wr_count, model.size() == 0} !== {1'b1, 5'd0, 5'd0, 1'b1}) begin
      n_bad++;
      $display("FAIL stream_end: empty=%b rd_count=%0d wr_count=%0d left=%0d, want 1 0 0 0",
        rd_empty, rd_count, wr_count, model.size());
    end
  endtask

  task automatic test_reset_mid;
    int k = 0;
    logic [7:0] d;
    for (int i = 0; i < 7; i++) write_word(8'h60 + i[7:0]);
    repeat (6) @(negedge rd_clk);
    n_cmp++;
    if (rd_count !== 5'd7) begin
      n_bad++;
      $display("FAIL mid_buffered: rd_count=%0d want 7", rd_count);
    end
    // start the pulse so that an rd_clk rising edge falls inside it
    do @(negedge wr_clk); while (($time % 10) == 6);
    reset = 0;
    fork
      begin
        repeat (2) @(negedge wr_clk);
        n_cmp++;
        if ({wr_full, wr_count} !== {1'b0, 5'd0}) begin
          n_bad++;
          $display("FAIL mid_wr_reset: wr_full=%b wr_count=%0d, want 0 0", wr_full, wr_count);
        end
        reset = 1;
      end
      do begin @(posedge rd_clk); k++; #1; end while (!rd_empty && k < S + 2);
    join
    n_cmp++;
    if (rd_empty !== 1'b1) begin
      n_bad++;
      $display("FAIL mid_rd_reset: rd_empty=%b after %0d rd edges, want 1", rd_empty, k);
    end
    repeat (6) @(negedge rd_clk);
    n_cmp++;
    if ({rd_empty, rd_count, wr_count} !== {1'b1, 5'd0, 5'd0}) begin
      n_bad++;
      $display("FAIL mid_after: empty=%b rd_count=%0d wr_count=%0d, want 1 0 0", rd_empty, rd_count, wr_count);
    end
    write_word(8'h55);
    read_word(d);
    n_cmp++;
    if (d !== 8'h55) begin
      n_bad++;
      $display("FAIL mid_readback: got %h want 55", d);
    end
  endtask

  initial begin
    test_reset;
    test_fill_drain;
    test_overflow;
    test_underflow;
    test_stream;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not finish by 20000 us");
    $fatal(1);
  end
endmodule
